// File: rtl/hilo_mdu.sv
// -----------------------------------------------------------------------------
// hilo_mdu
//
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// It sits in the EX stage beside the ALU. It runs MULT/MULTU with a fixed
// latency and DIV/DIVU as a 32-step restoring divider followed by a sign
// fix-up step. It also services MTHI/MTLO writes. All state changes on the
// falling edge of clk, which is the same edge the pipeline registers use.
//
// Ports:
//   clk        in   clock; state updates on the falling edge
//   reset      in   asynchronous, active-low reset
//   start      in   EX instruction is a mul/div (sampled only in IDLE)
//   op   [1:0] in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a   [31:0] in   rs operand (multiplicand / dividend)
//   b   [31:0] in   rt operand (multiplier / divisor)
//   mthi       in   write wdata to HI (IDLE, no start)
//   mtlo       in   write wdata to LO (IDLE, no start)
//   wdata[31:0] in  MTHI/MTLO data
//   use_hilo   in   EX instruction touches HI/LO or starts a mul/div
//   abort      in   cancel the in-flight operation (EX flush)
//   hi  [31:0] out  HI register
//   lo  [31:0] out  LO register
//   busy       out  operation in flight (state != IDLE)
//   stall_req  out  busy & use_hilo, drives the upstream pipeline stall
// -----------------------------------------------------------------------------
module hilo_mdu #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        use_hilo,
    input  logic        abort,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);

    // The counter has to hold both MUL_CYCLES-1 and the 31 divide steps.
    localparam int CW = (MUL_CYCLES > 32) ? $clog2(MUL_CYCLES) : 5;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [63:0]     r_prod;
    logic [31:0]     r_rem;
    logic [31:0]     r_quo;
    logic [31:0]     r_dvs;
    logic [31:0]     r_dvd_raw;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_dz;

    logic            w_signed_op;
    logic [63:0]     w_a_ext;
    logic [63:0]     w_b_ext;
    logic [63:0]     w_prod;
    logic [31:0]     w_abs_a;
    logic [31:0]     w_abs_b;
    logic [32:0]     w_rem_sh;
    logic [32:0]     w_diff;
    logic [31:0]     w_fix_q;
    logic [31:0]     w_fix_r;
    logic            w_cnt_zero;

    // op[0] set means the unsigned variant (MULTU / DIVU).
    assign w_signed_op = ~op[0];

    // Sign- or zero-extending to 64 bits lets a single unsigned 64x64
    // multiply produce the correct low 64 bits in both signed and unsigned
    // modes.
    assign w_a_ext = {{32{w_signed_op & a[31]}}, a};
    assign w_b_ext = {{32{w_signed_op & b[31]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_abs_a = (w_signed_op && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b = (w_signed_op && b[31]) ? (32'd0 - b) : b;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and trial-subtract the divisor. Bit 32 of the difference is the borrow.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};

    assign w_fix_q = r_qneg ? (32'd0 - r_quo) : r_quo;
    assign w_fix_r = r_rneg ? (32'd0 - r_rem) : r_rem;

    assign w_cnt_zero = (r_cnt == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = op[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = IDLE;
                    end
                end
                DIV: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = FIX;
                    end
                end
                FIX: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: operand latches, iteration, HI/LO
    // -------------------------------------------------------------------------
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_dvd_raw <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_dz      <= 1'b0;
        end else if (!abort) begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        if (op[1]) begin
                            r_rem     <= '0;
                            r_quo     <= w_abs_a;
                            r_dvs     <= w_abs_b;
                            r_dvd_raw <= a;
                            r_qneg    <= w_signed_op & (a[31] ^ b[31]);
                            r_rneg    <= w_signed_op & a[31];
                            r_dz      <= (b == '0);
                            r_cnt     <= CW'(31);
                        end else begin
                            r_prod    <= w_prod;
                            r_cnt     <= CW'(MUL_CYCLES - 1);
                        end
                    end else begin
                        if (mthi) begin
                            r_hi <= wdata;
                        end
                        if (mtlo) begin
                            r_lo <= wdata;
                        end
                    end
                end
                MUL: begin
                    if (w_cnt_zero) begin
                        r_hi <= r_prod[63:32];
                        r_lo <= r_prod[31:0];
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (w_diff[32]) begin
                        r_rem <= w_rem_sh[31:0];
                    end else begin
                        r_rem <= w_diff[31:0];
                    end
                    r_quo <= {r_quo[30:0], ~w_diff[32]};
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                FIX: begin
                    // A zero divisor makes every trial subtract succeed, so the
                    // quotient is already all ones. The remainder is reported as
                    // the raw dividend rather than its magnitude.
                    if (r_dz) begin
                        r_lo <= '1;
                        r_hi <= r_dvd_raw;
                    end else begin
                        r_lo <= w_fix_q;
                        r_hi <= w_fix_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = (r_state != IDLE);
    assign stall_req = busy & use_hilo;

endmodule

// File: tb/tb_hilo_mdu.sv
module tb_hilo_mdu;

    localparam int MUL_CYCLES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        use_hilo;
    logic        abort;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    int n_checks = 0;
    int n_errors = 0;

    // Reference view of the architectural HI/LO registers
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_mdu #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wdata     (wdata),
        .use_hilo  (use_hilo),
        .abort     (abort),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next active (falling) edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Architectural result of one mul/div, from plain integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sp;
        longint unsigned up;
        longint          sx;
        longint          sy;
        longint          q;
        longint          r;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    m_lo = 32'hFFFFFFFF;
                    m_hi = x;
                end else if (o == 2'b10) begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
        endcase
    endtask

    // Wait for busy to drop, checking stall_req follows busy while use_hilo=1.
    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (busy && n < 100) begin
            check({tag, ":stall"}, 64'(stall_req), 64'(1));
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        int n;
        int lat;
        lat = o[1] ? 33 : MUL_CYCLES;
        op = o; a = x; b = y; start = 1'b1; use_hilo = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ":busy"}, 64'(busy), 64'(1));
        wait_idle(tag, n);
        check({tag, ":lat"}, 64'(n), 64'(lat));
        model(o, x, y);
        check({tag, ":hi"}, 64'(hi), 64'(m_hi));
        check({tag, ":lo"}, 64'(lo), 64'(m_lo));
        check({tag, ":stall_off"}, 64'(stall_req), 64'(0));
        use_hilo = 1'b0;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        mthi = 1'b1; wdata = h;
        tick();
        mthi = 1'b0; mtlo = 1'b1; wdata = l;
        tick();
        mtlo = 1'b0;
        m_hi = h;
        m_lo = l;
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        int n;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; use_hilo = 1'b1; abort = 1'b0;
        m_hi = '0; m_lo = '0;

        #3;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_stall", 64'(stall_req), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        tick();
        reset = 1'b1;
        use_hilo = 1'b0;

        // Asynchronous reset in the middle of a divide
        set_hilo(32'hA5A5A5A5, 32'h5A5A5A5A);
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("pre_rst_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        #1;
        check("async_busy", 64'(busy), 64'(0));
        check("async_hi", 64'(hi), 64'(0));
        check("async_lo", 64'(lo), 64'(0));
        tick();
        reset = 1'b1;
        mtlo = 1'b1; wdata = 32'h1234;
        tick();
        mtlo = 1'b0;
        m_hi = '0; m_lo = 32'h1234;
        check("post_rst_lo", 64'(lo), 64'(32'h1234));
        check("post_rst_hi", 64'(hi), 64'(0));

        // Directed arithmetic cases with literal expectations
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, "mult");
        check("mult_hi_lit", 64'(hi), 64'(32'hFFFFFFFF));
        check("mult_lo_lit", 64'(lo), 64'(32'hFFFFFFF1));
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
        check("multu_hi_lit", 64'(hi), 64'(32'hFFFFFFFE));
        check("multu_lo_lit", 64'(lo), 64'(32'h00000001));
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, "div");
        check("div_lo_lit", 64'(lo), 64'(32'hFFFFFFFD));
        check("div_hi_lit", 64'(hi), 64'(32'hFFFFFFFF));
        run_op(2'b11, 32'd7, 32'd0, "divu0");
        check("divu0_lo_lit", 64'(lo), 64'(32'hFFFFFFFF));
        check("divu0_hi_lit", 64'(hi), 64'(32'd7));
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "divovf");
        check("divovf_lo_lit", 64'(lo), 64'(32'h80000000));
        check("divovf_hi_lit", 64'(hi), 64'(32'd0));
        run_op(2'b10, 32'hFFFFFFF9, 32'd0, "div0s");

        // MTHI while busy is ignored
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1; use_hilo = 1'b1;
        tick();
        start = 1'b0;
        mthi = 1'b1; wdata = 32'hDEADBEEF;
        tick();
        mthi = 1'b0;
        wait_idle("mthi_busy", n);
        check("mthi_busy_lat", 64'(n), 64'(32));
        check("mthi_busy_hi", 64'(hi), 64'(32'd2));
        check("mthi_busy_lo", 64'(lo), 64'(32'd14));
        use_hilo = 1'b0;

        // start + MTHI in IDLE: the multiply wins, MTHI dropped
        op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1; mthi = 1'b1; wdata = 32'hBEEF;
        use_hilo = 1'b1;
        tick();
        start = 1'b0; mthi = 1'b0;
        check("st_mthi_busy", 64'(busy), 64'(1));
        check("st_mthi_hi_hold", 64'(hi), 64'(32'd2));
        wait_idle("st_mthi", n);
        check("st_mthi_hi", 64'(hi), 64'(0));
        check("st_mthi_lo", 64'(lo), 64'(12));
        use_hilo = 1'b0;

        // Abort at the fifth edge of a divide
        set_hilo(32'hA, 32'hB);
        op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("abort_pre_busy", 64'(busy), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        check("abort_hi", 64'(hi), 64'(32'hA));
        check("abort_lo", 64'(lo), 64'(32'hB));

        // abort + start in IDLE: nothing starts
        abort = 1'b1; start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_busy", 64'(busy), 64'(0));
        tick();
        check("abort_start_hi", 64'(hi), 64'(32'hA));
        check("abort_start_lo", 64'(lo), 64'(32'hB));

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                set_hilo($urandom, $urandom);
            end
            run_op(ro, ra, rb, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
